// File: rtl/com_spi_sched.sv
// com_spi_sched: shares one SPI word engine between the host port (A) and a
// wirq-triggered poller (P). Word-granular round-robin arbitration, go/done
// sequencing, an inter-word csn gap and a hung-engine timeout.
//
// Handshakes:
//   Port A: a_valid/a_data are held by the requester. a_ready is a one-cycle
//           pulse in the grant cycle; a_data is captured on that same rising
//           edge and may change afterwards. Responses (a_rsp_*, p_rsp_*) are
//           one-cycle pulses with no backpressure; *_rsp_err is only ever high
//           together with its *_rsp_valid.
//   Engine: m_go pulses for one cycle; m_tx_data is stable from m_go until
//           m_done; m_rx_data is sampled only with m_done while in WAIT.
module com_spi_sched #(
  parameter int                WORD_W     = 16,
  parameter int                GAP_CYCLES = 4,
  parameter logic [WORD_W-1:0] POLL_WORD  = '0,
  parameter int                TIMEOUT    = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [WORD_W-1:0] a_data,
  output logic              a_ready,
  output logic              a_rsp_valid,
  output logic [WORD_W-1:0] a_rsp_data,
  output logic              a_rsp_err,
  input  logic              com_wirq,
  input  logic              poll_en,
  input  logic [3:0]        poll_len,
  output logic              p_rsp_valid,
  output logic [WORD_W-1:0] p_rsp_data,
  output logic              p_rsp_err,
  output logic              poll_overrun,
  input  logic              clr_overrun,
  output logic              m_go,
  output logic [WORD_W-1:0] m_tx_data,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [WORD_W-1:0] m_rx_data,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int TO_W  = (TIMEOUT > 0)    ? $clog2(TIMEOUT + 1)    : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [2:0]       wirq_sync;      // [0],[1] synchronizer, [2] edge register
  logic             wirq_edge;
  logic [3:0]       poll_rem;
  logic             last_grant_p;   // 1: poller owned the previous word
  logic             owner_p;        // owner of the word in flight
  logic [TO_W-1:0]  to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             grant_a, grant_p;
  logic             timeout_hit;
  logic             rsp_fire, rsp_err_nx;

  assign wirq_edge = wirq_sync[1] & ~wirq_sync[2];
  assign dbg_state = state;
  assign m_go      = (state == S_ISSUE);
  assign a_ready   = grant_a;
  assign busy      = (state != S_IDLE) || (poll_rem != 4'd0);

  // Abort once the word has spent TIMEOUT cycles in WAIT (0 disables).
  assign timeout_hit = (TIMEOUT != 0) && (int'(to_cnt) >= TIMEOUT - 1);

  // Arbitration: only in IDLE with the engine free; ties go to whoever did
  // not own the previous word. rst_n gates the grant so a_ready is low in reset.
  always_comb begin
    grant_a = 1'b0;
    grant_p = 1'b0;
    if (rst_n && state == S_IDLE && !m_busy) begin
      if (a_valid && poll_rem != 4'd0) begin
        grant_a = last_grant_p;
        grant_p = ~last_grant_p;
      end else begin
        grant_a = a_valid;
        grant_p = (poll_rem != 4'd0);
      end
    end
  end

  // Next-state and response-fire decode.
  always_comb begin
    state_nx   = state;
    rsp_fire   = 1'b0;
    rsp_err_nx = 1'b0;
    case (state)
      S_IDLE:  if (grant_a || grant_p) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        if (m_done) begin
          state_nx = S_GAP;
          rsp_fire = 1'b1;
        end else if (timeout_hit) begin
          state_nx   = S_GAP;
          rsp_fire   = 1'b1;
          rsp_err_nx = 1'b1;
        end
      end
      S_GAP:   if (gap_cnt == GAP_W'(GAP_CYCLES)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Grant bookkeeping, tx word latch, timeout and gap counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tx_data    <= '0;
      owner_p      <= 1'b0;
      last_grant_p <= 1'b1;
      to_cnt       <= '0;
      gap_cnt      <= '0;
    end else begin
      if (grant_a || grant_p) begin
        m_tx_data    <= grant_a ? a_data : POLL_WORD;
        owner_p      <= grant_p;
        last_grant_p <= grant_p;
      end
      if (state == S_ISSUE)                   to_cnt <= '0;
      else if (state == S_WAIT && to_cnt != '1) to_cnt <= to_cnt + 1'b1;
      if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
      else                gap_cnt <= '0;
    end
  end

  // Response pulses routed to the owner; timed-out words report zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rsp_valid <= 1'b0;
      a_rsp_err   <= 1'b0;
      a_rsp_data  <= '0;
      p_rsp_valid <= 1'b0;
      p_rsp_err   <= 1'b0;
      p_rsp_data  <= '0;
    end else begin
      a_rsp_valid <= 1'b0;
      a_rsp_err   <= 1'b0;
      p_rsp_valid <= 1'b0;
      p_rsp_err   <= 1'b0;
      if (rsp_fire) begin
        if (owner_p) begin
          p_rsp_valid <= 1'b1;
          p_rsp_err   <= rsp_err_nx;
          p_rsp_data  <= rsp_err_nx ? '0 : m_rx_data;
        end else begin
          a_rsp_valid <= 1'b1;
          a_rsp_err   <= rsp_err_nx;
          a_rsp_data  <= rsp_err_nx ? '0 : m_rx_data;
        end
      end
    end
  end

  // wirq synchronizer plus edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wirq_sync <= 3'b000;
    else        wirq_sync <= {wirq_sync[1:0], com_wirq};
  end

  // Poll burst counter: load on a fresh edge, count down per poll grant,
  // dropped entirely while polling is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_rem <= 4'd0;
    end else if (!poll_en) begin
      poll_rem <= 4'd0;
    end else if (wirq_edge && poll_rem == 4'd0 && poll_len != 4'd0) begin
      poll_rem <= poll_len;
    end else if (grant_p) begin
      poll_rem <= poll_rem - 4'd1;
    end
  end

  // Sticky overrun: an edge during an outstanding burst; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        poll_overrun <= 1'b0;
    else if (wirq_edge && poll_en && poll_rem != 4'd0) poll_overrun <= 1'b1;
    else if (clr_overrun)                              poll_overrun <= 1'b0;
  end

endmodule
